// File: rtl/ltl_cluster_monitor_hub.sv
// Cluster-level LTL monitor hub: folds per-stage automata hits into one verdict per
// property and keeps sticky status, saturating counters, a first-violation record and a
// valid/ready report stream for the runtime-monitor CSR/interrupt logic.
module ltl_cluster_monitor_hub #(
  parameter int unsigned NUM_PROPS  = 10,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned SYM_W      = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TS_W       = 32,
  localparam int unsigned IDX_W     = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic [SYM_W-1:0]                symbols,
  input  logic [NUM_PROPS*NUM_STAGES-1:0] stage_hits,
  input  logic [NUM_PROPS-1:0]            mask,
  input  logic                            clear,
  output logic [NUM_PROPS-1:0]            hit_now,
  output logic [NUM_PROPS-1:0]            sticky,
  output logic                            any_violation,
  output logic                            first_valid,
  output logic [IDX_W-1:0]                first_prop,
  output logic [SYM_W-1:0]                first_symbol,
  output logic [TS_W-1:0]                 first_ts,
  input  logic [IDX_W-1:0]                count_sel,
  output logic [CNT_W-1:0]                count_value,
  output logic                            rpt_valid,
  input  logic                            rpt_ready,
  output logic [IDX_W-1:0]                rpt_prop,
  output logic [SYM_W-1:0]                rpt_symbol,
  output logic                            rpt_overrun
);

  typedef enum logic {StIdle, StPresent} rpt_state_e;

  rpt_state_e             state_q, state_d;
  logic [NUM_PROPS-1:0]   e_hit;
  logic [NUM_PROPS-1:0]   sticky_q, pending_q;
  logic                   any_q, first_valid_q, overrun_q, hs;
  logic [IDX_W-1:0]       first_prop_q, rpt_prop_q, rpt_prop_d, e_low, pend_low;
  logic [SYM_W-1:0]       first_symbol_q, rpt_symbol_q, rpt_symbol_d;
  logic [TS_W-1:0]        ts_q, first_ts_q;
  logic [CNT_W-1:0]       cnt_q  [NUM_PROPS];
  logic [SYM_W-1:0]       psym_q [NUM_PROPS];

  // Priority pick: lowest set index wins.
  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_PROPS-1:0] v);
    lowest = '0;
    for (int i = int'(NUM_PROPS) - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDX_W'(i);
    end
  endfunction

  // Per-property verdict, effective hits and priority picks.
  always_comb begin
    hit_now = '0;
    for (int p = 0; p < int'(NUM_PROPS); p++) begin
      hit_now[p] = (|stage_hits[p*NUM_STAGES +: NUM_STAGES]) & ~mask[p];
    end
    e_hit    = hit_now & {NUM_PROPS{run & ~clear}};
    e_low    = lowest(e_hit);
    pend_low = lowest(pending_q);
  end

  // Timestamp advances on every run cycle; soft clear leaves it alone.
  always_ff @(posedge clk) begin
    if (reset)    ts_q <= '0;
    else if (run) ts_q <= ts_q + 1'b1;
  end

  // Sticky status, aggregate flag and saturating counters.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sticky_q <= '0;
      any_q    <= 1'b0;
      for (int p = 0; p < int'(NUM_PROPS); p++) cnt_q[p] <= '0;
    end else begin
      sticky_q <= sticky_q | e_hit;
      any_q    <= |(sticky_q | e_hit);
      for (int p = 0; p < int'(NUM_PROPS); p++) begin
        if (e_hit[p] && (cnt_q[p] != '1)) cnt_q[p] <= cnt_q[p] + 1'b1;
      end
    end
  end

  // First-violation capture uses the timestamp before this cycle's increment.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      first_valid_q  <= 1'b0;
      first_prop_q   <= '0;
      first_symbol_q <= '0;
      first_ts_q     <= '0;
    end else if (!first_valid_q && (|e_hit)) begin
      first_valid_q  <= 1'b1;
      first_prop_q   <= e_low;
      first_symbol_q <= symbols;
      first_ts_q     <= ts_q;
    end
  end

  // Pending bits with their captured symbols; a hit that lands on the property being
  // accepted right now re-arms it instead of counting as an overrun.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pending_q <= '0;
      overrun_q <= 1'b0;
      for (int p = 0; p < int'(NUM_PROPS); p++) psym_q[p] <= '0;
    end else begin
      for (int p = 0; p < int'(NUM_PROPS); p++) begin
        if (e_hit[p]) begin
          if (!pending_q[p] || (hs && (rpt_prop_q == IDX_W'(p)))) begin
            pending_q[p] <= 1'b1;
            psym_q[p]    <= symbols;
          end else begin
            overrun_q <= 1'b1;
          end
        end else if (hs && (rpt_prop_q == IDX_W'(p))) begin
          pending_q[p] <= 1'b0;
        end
      end
    end
  end

  // Report FSM state and latched report fields.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q      <= StIdle;
      rpt_prop_q   <= '0;
      rpt_symbol_q <= '0;
    end else begin
      state_q      <= state_d;
      rpt_prop_q   <= rpt_prop_d;
      rpt_symbol_q <= rpt_symbol_d;
    end
  end

  // Report FSM next state: latch in IDLE, present until accepted.
  always_comb begin
    state_d      = state_q;
    rpt_prop_d   = rpt_prop_q;
    rpt_symbol_d = rpt_symbol_q;
    rpt_valid    = 1'b0;
    hs           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|pending_q) begin
          rpt_prop_d   = pend_low;
          rpt_symbol_d = psym_q[pend_low];
          state_d      = StPresent;
        end
      end
      StPresent: begin
        rpt_valid = 1'b1;
        if (rpt_ready) begin
          hs      = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter read port; out-of-range selects read as zero.
  always_comb begin
    count_value = '0;
    if (32'(count_sel) < NUM_PROPS) count_value = cnt_q[count_sel];
  end

  assign sticky        = sticky_q;
  assign any_violation = any_q;
  assign first_valid   = first_valid_q;
  assign first_prop    = first_prop_q;
  assign first_symbol  = first_symbol_q;
  assign first_ts      = first_ts_q;
  assign rpt_prop      = rpt_prop_q;
  assign rpt_symbol    = rpt_symbol_q;
  assign rpt_overrun   = overrun_q;

endmodule

// File: tb/tb_ltl_cluster_monitor_hub.sv
// Self-checking bench for ltl_cluster_monitor_hub: vector table for the verdict logic,
// directed corner sequences and randomized traffic against a behavioural model.
module tb_ltl_cluster_monitor_hub;
  localparam int NP = 10;
  localparam int NS = 4;
  localparam int SW = 8;
  localparam int CW = 4;
  localparam int TW = 32;
  localparam int IW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset, run, clear, rpt_ready;
  logic [SW-1:0]     symbols;
  logic [NP*NS-1:0]  stage_hits;
  logic [NP-1:0]     mask;
  logic [IW-1:0]     count_sel;
  logic [NP-1:0]     hit_now, sticky;
  logic              any_violation, first_valid, rpt_valid, rpt_overrun;
  logic [IW-1:0]     first_prop, rpt_prop;
  logic [SW-1:0]     first_symbol, rpt_symbol;
  logic [TW-1:0]     first_ts;
  logic [CW-1:0]     count_value;

  always #5 clk = ~clk;

  ltl_cluster_monitor_hub #(.NUM_PROPS(NP), .NUM_STAGES(NS), .SYM_W(SW), .CNT_W(CW),
                            .TS_W(TW)) dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols), .stage_hits(stage_hits),
    .mask(mask), .clear(clear), .hit_now(hit_now), .sticky(sticky),
    .any_violation(any_violation), .first_valid(first_valid), .first_prop(first_prop),
    .first_symbol(first_symbol), .first_ts(first_ts), .count_sel(count_sel),
    .count_value(count_value), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_prop(rpt_prop), .rpt_symbol(rpt_symbol), .rpt_overrun(rpt_overrun)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model state
  bit [NP-1:0] m_sticky, m_pend;
  int          m_cnt [NP];
  logic [7:0]  m_psym [NP];
  bit          m_any, m_fv, m_ovr, m_rv;
  int          m_fp, m_rp;
  logic [7:0]  m_fs, m_rs;
  logic [31:0] m_ts, m_fts;

  function automatic bit [NP-1:0] hit_ref();
    bit [NP-1:0] r;
    for (int p = 0; p < NP; p++)
      r[p] = (((stage_hits >> (p * NS)) & 40'hF) != 0) && !mask[p];
    return r;
  endfunction

  function automatic int low_idx(input bit [NP-1:0] v);
    for (int p = 0; p < NP; p++) if (v[p]) return p;
    return 0;
  endfunction

  task automatic model_clear();
    m_sticky = '0; m_pend = '0; m_any = 0; m_fv = 0; m_ovr = 0; m_rv = 0;
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_ts = 0;
    for (int p = 0; p < NP; p++) m_psym[p] = 0;
  endtask

  // Advance the model by one clock using the inputs applied during that cycle.
  task automatic model_update();
    bit [NP-1:0] e, old_pend;
    bit hs;
    int old_rp, pick;
    e = hit_ref() & {NP{run && !clear}};
    if (clear) begin
      model_clear();
    end else begin
      hs = m_rv && rpt_ready;
      old_rp = m_rp;
      old_pend = m_pend;
      // report stream: one report at a time, an idle cycle between reports
      if (m_rv) begin
        if (hs) m_rv = 0;
      end else if (old_pend != 0) begin
        pick = low_idx(old_pend);
        m_rp = pick; m_rs = m_psym[pick]; m_rv = 1;
      end
      if (!m_fv && e != 0) begin
        m_fv = 1; m_fp = low_idx(e); m_fs = symbols; m_fts = m_ts;
      end
      for (int p = 0; p < NP; p++) begin
        if (e[p]) begin
          m_sticky[p] = 1;
          if (m_cnt[p] < CMAX) m_cnt[p]++;
          if (!old_pend[p] || (hs && old_rp == p)) begin
            m_pend[p] = 1; m_psym[p] = symbols;
          end else m_ovr = 1;
        end else if (hs && old_rp == p) m_pend[p] = 0;
      end
      m_any = (m_sticky != 0);
    end
    if (run) m_ts++;
  endtask

  task automatic check_all();
    int exp_cnt;
    exp_cnt = (count_sel < NP) ? m_cnt[count_sel] : 0;
    chk("hit_now", hit_now, hit_ref());
    chk("sticky", sticky, m_sticky);
    chk("any_violation", any_violation, m_any);
    chk("first_valid", first_valid, m_fv);
    if (m_fv) begin
      chk("first_prop", first_prop, m_fp);
      chk("first_symbol", first_symbol, m_fs);
      chk("first_ts", first_ts, m_fts);
    end
    chk("count_value", count_value, exp_cnt);
    chk("rpt_valid", rpt_valid, m_rv);
    if (m_rv) begin
      chk("rpt_prop", rpt_prop, m_rp);
      chk("rpt_symbol", rpt_symbol, m_rs);
    end
    chk("rpt_overrun", rpt_overrun, m_ovr);
  endtask

  task automatic step();
    #2 check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_clear();
    clear = 1; stage_hits = '0; step(); clear = 0;
  endtask

  typedef struct {
    logic [NP*NS-1:0] hits;
    logic [NP-1:0]    msk;
    logic             rn;
    logic [NP-1:0]    exp_hit;
  } vec_t;
  vec_t tbl[6];

  logic [31:0] t_save;
  logic [NP-1:0] sticky_save;

  initial begin
    tbl[0] = '{hits: 40'h1 << 14, msk: 10'h000, rn: 1'b1, exp_hit: 10'h008};
    tbl[1] = '{hits: 40'h0, msk: 10'h000, rn: 1'b1, exp_hit: 10'h000};
    tbl[2] = '{hits: {40{1'b1}}, msk: 10'h000, rn: 1'b1, exp_hit: 10'h3FF};
    tbl[3] = '{hits: {40{1'b1}}, msk: 10'h155, rn: 1'b1, exp_hit: 10'h2AA};
    tbl[4] = '{hits: (40'h1 << 4) | (40'h1 << 31), msk: 10'h000, rn: 1'b0, exp_hit: 10'h082};
    tbl[5] = '{hits: 40'h1 << 37, msk: 10'h200, rn: 1'b1, exp_hit: 10'h000};

    reset = 1; run = 0; clear = 0; rpt_ready = 0; symbols = '0; stage_hits = '0;
    mask = '0; count_sel = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1 reset = 0;
    chk("reset_sticky", sticky, 0);
    chk("reset_any", any_violation, 0);
    chk("reset_first_valid", first_valid, 0);
    chk("reset_rpt_valid", rpt_valid, 0);
    chk("reset_overrun", rpt_overrun, 0);
    chk("reset_count", count_value, 0);

    // verdict table
    for (int i = 0; i < 6; i++) begin
      stage_hits = tbl[i].hits; mask = tbl[i].msk; run = tbl[i].rn;
      symbols = 8'(i + 1);
      #2 chk("tbl_hit_now", hit_now, tbl[i].exp_hit);
      step();
    end
    mask = '0; run = 1;
    do_clear();
    rpt_ready = 1; repeat (6) step(); rpt_ready = 0;

    // single hit on prop 3: status at +1, report at +2
    run = 1; symbols = 8'h5A; stage_hits = 40'h1 << 14; t_save = m_ts;
    #2 chk("t1_hit_now", hit_now, 10'h008);
    step(); stage_hits = '0;
    chk("t1_sticky", sticky, 10'h008);
    chk("t1_any", any_violation, 1);
    chk("t1_first_prop", first_prop, 3);
    chk("t1_first_symbol", first_symbol, 8'h5A);
    chk("t1_first_ts", first_ts, t_save);
    step();
    chk("t1_rpt_valid", rpt_valid, 1);
    chk("t1_rpt_prop", rpt_prop, 3);
    chk("t1_rpt_symbol", rpt_symbol, 8'h5A);
    rpt_ready = 1; step(); rpt_ready = 0;

    // props 1 and 7 together: reports two cycles apart, lowest first
    do_clear();
    rpt_ready = 1; stage_hits = (40'h1 << 4) | (40'h1 << 28); symbols = 8'hC3;
    step(); stage_hits = '0;
    step();
    chk("t2_rpt1_valid", rpt_valid, 1);
    chk("t2_rpt1_prop", rpt_prop, 1);
    step();
    chk("t2_gap", rpt_valid, 0);
    step();
    chk("t2_rpt2_valid", rpt_valid, 1);
    chk("t2_rpt2_prop", rpt_prop, 7);
    chk("t2_first_prop", first_prop, 1);
    count_sel = 7;
    #2 chk("t2_count7", count_value, 1);
    step(); rpt_ready = 0;

    // run=0 freezes status; masked property has no effect
    run = 0; stage_hits = 40'h1 << 16; sticky_save = sticky;
    #2 chk("t3_hit_now4", hit_now[4], 1);
    step();
    chk("t3_sticky_frozen", sticky, sticky_save);
    run = 1; mask = 10'h020; stage_hits = 40'hF << 20; count_sel = 5;
    #2 chk("t3_masked_hit", hit_now[5], 0);
    step(); step();
    chk("t3_masked_sticky", sticky[5], 0);
    chk("t3_masked_count", count_value, 0);
    mask = '0; stage_hits = '0;

    // counter saturation
    do_clear();
    rpt_ready = 1; count_sel = 0; stage_hits = 40'h1;
    repeat (20) step();
    stage_hits = '0; step();
    chk("t4_saturated", count_value, CMAX);
    step();
    chk("t4_held", count_value, CMAX);
    rpt_ready = 0; step();

    // overrun while report stalled
    do_clear();
    stage_hits = 40'h1 << 8; step(); stage_hits = '0; step();
    stage_hits = 40'h1 << 9; step(); stage_hits = '0; step();
    chk("t5_rpt_valid", rpt_valid, 1);
    chk("t5_rpt_prop", rpt_prop, 2);
    chk("t5_overrun", rpt_overrun, 1);
    rpt_ready = 1; step(); rpt_ready = 0;
    chk("t5_after_hs", rpt_valid, 0);
    step();

    // clear aborts an in-flight report and discards a same-cycle hit
    do_clear();
    stage_hits = 40'h1 << 12; step(); stage_hits = '0; step();
    chk("t6_pre_valid", rpt_valid, 1);
    clear = 1; stage_hits = 40'h1 << 24; step(); clear = 0; stage_hits = '0;
    chk("t6_sticky", sticky, 0);
    chk("t6_rpt_valid", rpt_valid, 0);
    chk("t6_first_valid", first_valid, 0);
    chk("t6_any", any_violation, 0);
    step();
    chk("t6_still_idle", rpt_valid, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      run = ($urandom % 8) != 0;
      clear = ($urandom % 120) == 0;
      rpt_ready = $urandom % 2;
      symbols = 8'($urandom);
      count_sel = 4'($urandom % 16);
      stage_hits = '0;
      if ($urandom % 3 == 0) stage_hits[$urandom % 40] = 1'b1;
      if ($urandom % 6 == 0) stage_hits[$urandom % 40] = 1'b1;
      if ($urandom % 50 == 0) mask = 10'($urandom) & 10'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
